// File: rtl/qsys_pio_in_edge_irq.sv
// Avalon-MM input PIO: synchroniser, optional per-bit debounce, edge capture and maskable level IRQ.
// Read latency 1 clock; no backpressure (slave always accepts, readdata tracks address every clock).
module qsys_pio_in_edge_irq #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int PRIME_RAW = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam logic [3:0] PRIME_TGT = (PRIME_RAW > 15) ? 4'd15 : 4'(PRIME_RAW);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] edge_capture_q;
  logic [WIDTH-1:0] edge_det;
  logic [3:0]       prime_q;
  logic             primed;
  logic             wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_deb
      assign stable = sync;
    end else begin : g_deb
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [CNT_W-1:0] cnt_q [WIDTH];
      logic [WIDTH-1:0] stable_q;

      // A bit is accepted only after DEBOUNCE_CYCLES consecutive clocks of disagreement.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stable_q <= '0;
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable_q[i]) begin
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
              stable_q[i] <= sync[i];
              cnt_q[i]    <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 1'b1;
            end
          end
        end
      end

      assign stable = stable_q;
    end
  endgenerate

  // Hold off edge detection until the pipeline holds real pin values after reset.
  assign primed = (prime_q == PRIME_TGT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q <= '0;
      prev_q  <= '0;
    end else begin
      if (!primed) prime_q <= prime_q + 4'd1;
      prev_q <= stable;
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = stable & ~prev_q;
      1:       edge_det = ~stable & prev_q;
      default: edge_det = stable ^ prev_q;
    endcase
    if (!primed) edge_det = '0;
  end

  assign wr_en = chipselect && !write_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      if (wr_en && address == 2'd2) irq_mask_q <= writedata[WIDTH-1:0];
      // A new edge in the same clock as its W1C clear keeps the bit set.
      if (wr_en && address == 2'd3)
        edge_capture_q <= (edge_capture_q & ~writedata[WIDTH-1:0]) | edge_det;
      else
        edge_capture_q <= edge_capture_q | edge_det;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= '0;
      case (address)
        2'd0:    readdata[WIDTH-1:0] <= stable;
        2'd2:    readdata[WIDTH-1:0] <= irq_mask_q;
        2'd3:    readdata[WIDTH-1:0] <= edge_capture_q;
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edge_capture_q & irq_mask_q);

  logic unused_ok;
  assign unused_ok = &{1'b0, writedata};

endmodule
